// File: rtl/branch_redirect_ctrl_if.sv
// Shared branch-kind/state types and the execute/fetch-facing bundle of the
// branch redirect controller. The master side is execute plus fetch; the slave
// side is the controller.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both 1. A valid, once raised, holds its payload steady until that edge.
// br_valid/br_ready carry one branch in. redir_valid/redir_ready carry one
// redirect out, and redir_pc stays stable while redir_valid is high.

package branch_redirect_ctrl_pkg;

  typedef enum logic [2:0] {
    bk_beq     = 3'd0,
    bk_bne     = 3'd1,
    bk_blt     = 3'd2,
    bk_bge     = 3'd3,
    bk_bltu    = 3'd4,
    bk_bgeu    = 3'd5,
    bk_invalid = 3'd7
  } branch_kind_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_FLUSH    = 2'd2
  } brc_state_t;

endpackage

interface branch_redirect_ctrl_if #(
  parameter int XLEN = 32
);
  import branch_redirect_ctrl_pkg::*;

  logic              br_valid;
  logic              br_ready;
  branch_kind_t      br_kind;
  logic [XLEN-1:0]   br_pc;
  logic [XLEN-1:0]   br_imm;
  logic [XLEN-1:0]   br_rs1;
  logic [XLEN-1:0]   br_rs2;
  logic              br_pred_taken;
  logic [XLEN-1:0]   pred_pc;
  logic              pred_taken;
  logic              redir_valid;
  logic              redir_ready;
  logic [XLEN-1:0]   redir_pc;
  logic              flush;
  logic              illegal;
  brc_state_t        state_dbg;

  modport master (
    output br_valid, br_kind, br_pc, br_imm, br_rs1, br_rs2, br_pred_taken,
    output pred_pc, redir_ready,
    input  br_ready, pred_taken, redir_valid, redir_pc, flush, illegal, state_dbg
  );

  modport slave (
    input  br_valid, br_kind, br_pc, br_imm, br_rs1, br_rs2, br_pred_taken,
    input  pred_pc, redir_ready,
    output br_ready, pred_taken, redir_valid, redir_pc, flush, illegal, state_dbg
  );

endinterface

// File: rtl/branch_redirect_ctrl.sv
// Branch redirect controller. It resolves RV32I conditional branches, trains a
// table of 2-bit saturating counters, and on a mispredict sequences front-end
// recovery: first a redirect handshake to fetch, then a fixed flush window.
// The current FSM state is exported on bus.state_dbg.

module branch_redirect_ctrl #(
  parameter int XLEN         = 32,
  parameter int BHT_ENTRIES  = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  branch_redirect_ctrl_if.slave  bus
);
  import branch_redirect_ctrl_pkg::*;

  localparam int IW = $clog2(BHT_ENTRIES);
  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam logic [CW-1:0] FLUSH_LOAD = CW'(FLUSH_CYCLES);

  brc_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]  redir_pc_q;
  logic             illegal_q;
  logic [1:0]       bht_q [BHT_ENTRIES];

  logic             accept;
  logic             is_invalid;
  logic             taken;
  logic             mispredict;
  logic [XLEN-1:0]  target;
  logic [IW-1:0]    upd_idx;
  logic [IW-1:0]    rd_idx;
  logic             pc_bits_unused;

  // Word-aligned PCs index the table; the byte offset and the upper bits are ignored.
  assign upd_idx = bus.br_pc[IW+1:2];
  assign rd_idx  = bus.pred_pc[IW+1:2];
  assign pc_bits_unused = ^{bus.pred_pc[XLEN-1:IW+2], bus.pred_pc[1:0]};

  assign accept     = bus.br_valid & bus.br_ready;
  assign is_invalid = (bus.br_kind == bk_invalid);
  assign mispredict = (taken != bus.br_pred_taken);
  // The adder wraps at 2^XLEN, so a branch at the top of memory lands at low addresses.
  assign target     = bus.br_pc + (taken ? bus.br_imm : XLEN'(4));

  // Compare the operands for each branch kind.
  always_comb begin
    taken = 1'b0;
    case (bus.br_kind)
      bk_beq:  taken = (bus.br_rs1 == bus.br_rs2);
      bk_bne:  taken = (bus.br_rs1 != bus.br_rs2);
      bk_blt:  taken = ($signed(bus.br_rs1) <  $signed(bus.br_rs2));
      bk_bge:  taken = ($signed(bus.br_rs1) >= $signed(bus.br_rs2));
      bk_bltu: taken = (bus.br_rs1 <  bus.br_rs2);
      bk_bgeu: taken = (bus.br_rs1 >= bus.br_rs2);
      default: taken = 1'b0;
    endcase
  end

  // Next-state logic for the IDLE -> REDIRECT -> FLUSH recovery sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && !is_invalid && mispredict) state_d = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        if (bus.redir_ready) begin
          if (FLUSH_CYCLES == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_FLUSH;
            cnt_d   = FLUSH_LOAD;
          end
        end
      end
      ST_FLUSH: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, flush counter, latched redirect target and the illegal-kind pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      redir_pc_q <= '0;
      illegal_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= accept & is_invalid;
      if (accept && !is_invalid && mispredict) redir_pc_q <= target;
    end
  end

  // Train the counter of the resolved branch; it saturates at both ends.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
    end else if (accept && !is_invalid) begin
      if (taken) begin
        if (bht_q[upd_idx] != 2'b11) bht_q[upd_idx] <= bht_q[upd_idx] + 2'b01;
      end else begin
        if (bht_q[upd_idx] != 2'b00) bht_q[upd_idx] <= bht_q[upd_idx] - 2'b01;
      end
    end
  end

  // br_ready is gated by rst so that no branch is accepted while reset is held.
  assign bus.br_ready    = rst & (state_q == ST_IDLE);
  assign bus.redir_valid = (state_q == ST_REDIRECT);
  assign bus.flush       = (state_q == ST_REDIRECT) | (state_q == ST_FLUSH);
  assign bus.redir_pc    = redir_pc_q;
  assign bus.illegal     = illegal_q;
  // The lookup reads the registered counter, so an update in the same cycle is not visible yet.
  assign bus.pred_taken  = bht_q[rd_idx][1];
  assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Bench for branch_redirect_ctrl: a hand-derived vector table, a redirect/flush
// sequencer, and hand-written reset corner cases.
module tb_branch_redirect_ctrl;
  import branch_redirect_ctrl_pkg::*;

  localparam int XLEN = 32;
  localparam int W    = XLEN + 1;

  typedef struct {
    branch_kind_t     kind;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  rs1;
    logic [XLEN-1:0]  rs2;
    logic             pred;
    logic [XLEN-1:0]  ppc;
    logic             exp_redir;
    logic [XLEN-1:0]  exp_pc;
    logic             exp_pt;
    logic             exp_ill;
    int               hold;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  branch_redirect_ctrl_if #(.XLEN(XLEN)) bus ();

  branch_redirect_ctrl #(
    .XLEN(XLEN), .BHT_ENTRIES(16), .FLUSH_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  vec_t tbl [18];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input branch_kind_t kind, input logic [XLEN-1:0] pc,
                              input logic [XLEN-1:0] imm, input logic [XLEN-1:0] rs1,
                              input logic [XLEN-1:0] rs2, input logic pred,
                              input logic [XLEN-1:0] ppc, input logic er,
                              input logic [XLEN-1:0] epc, input logic ept,
                              input logic eill, input int hold);
    vec_t v;
    v.kind = kind; v.pc = pc; v.imm = imm; v.rs1 = rs1; v.rs2 = rs2; v.pred = pred;
    v.ppc = ppc; v.exp_redir = er; v.exp_pc = epc; v.exp_pt = ept; v.exp_ill = eill;
    v.hold = hold;
    return v;
  endfunction

  // Drive one branch; the caller sits at a negedge. Ends at the negedge after the accept edge.
  task automatic drive_branch(input vec_t v);
    int waited = 0;
    while (!bus.br_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.br_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: got br_ready=0 expected 1");
    end
    bus.br_valid      = 1'b1;
    bus.br_kind       = v.kind;
    bus.br_pc         = v.pc;
    bus.br_imm        = v.imm;
    bus.br_rs1        = v.rs1;
    bus.br_rs2        = v.rs2;
    bus.br_pred_taken = v.pred;
    bus.pred_pc       = v.ppc;
    exp_q.push_back({v.exp_redir, v.exp_pc});
    @(posedge clk);
    #1;
    bus.br_valid = 1'b0;
    bus.br_rs1   = $urandom;
    bus.br_rs2   = $urandom;
    bus.br_imm   = $urandom;
    @(negedge clk);
  endtask

  // Hold off the redirect for v.hold cycles while offering a branch, then take the flush window.
  task automatic finish_redirect(input vec_t v);
    for (int i = 0; i < v.hold; i++) begin
      bus.br_valid      = 1'b1;
      bus.br_kind       = bk_bne;
      bus.br_pc         = v.pc;
      bus.br_rs1        = 32'd1;
      bus.br_rs2        = 32'd2;
      bus.br_pred_taken = 1'b0;
      @(negedge clk);
      check("hold_redir_valid", bus.redir_valid, 1);
      check("hold_redir_pc", bus.redir_pc, v.exp_pc);
      check("hold_flush", bus.flush, 1);
      check("hold_br_ready", bus.br_ready, 0);
      check("hold_pred_taken", bus.pred_taken, v.exp_pt);
    end
    bus.br_valid    = 1'b0;
    bus.redir_ready = 1'b1;
    @(negedge clk);
    check("flush1_redir_valid", bus.redir_valid, 0);
    check("flush1_flush", bus.flush, 1);
    check("flush1_br_ready", bus.br_ready, 0);
    bus.redir_ready = 1'b0;
    @(negedge clk);
    check("flush2_flush", bus.flush, 1);
    check("flush2_br_ready", bus.br_ready, 0);
    @(negedge clk);
    check("idle_flush", bus.flush, 0);
    check("idle_br_ready", bus.br_ready, 1);
  endtask

  task automatic send(input vec_t v, input int k);
    logic [W-1:0] e;
    drive_branch(v);
    e = exp_q.pop_front();
    check($sformatf("v%0d_redir_valid", k), bus.redir_valid, e[XLEN]);
    check($sformatf("v%0d_pred_taken", k), bus.pred_taken, v.exp_pt);
    check($sformatf("v%0d_illegal", k), bus.illegal, v.exp_ill);
    if (e[XLEN]) begin
      check($sformatf("v%0d_redir_pc", k), bus.redir_pc, e[XLEN-1:0]);
      check($sformatf("v%0d_flush", k), bus.flush, 1);
      check($sformatf("v%0d_br_ready", k), bus.br_ready, 0);
      finish_redirect(v);
    end else begin
      check($sformatf("v%0d_flush", k), bus.flush, 0);
      check($sformatf("v%0d_br_ready", k), bus.br_ready, 1);
    end
  endtask

  initial begin
    //          kind        pc            imm           rs1           rs2           pred ppc           redir pc           pt ill hold
    tbl[0]  = mk(bk_bne,     32'h40,       32'h100,      32'h1,        32'h2,        0, 32'h40,       1, 32'h140,       1, 0, 0);
    tbl[1]  = mk(bk_bne,     32'h40,       32'h100,      32'h1,        32'h2,        1, 32'h40,       0, 32'h0,         1, 0, 0);
    tbl[2]  = mk(bk_bne,     32'h40,       32'h100,      32'h1,        32'h2,        1, 32'h40,       0, 32'h0,         1, 0, 0);
    tbl[3]  = mk(bk_beq,     32'h100,      32'h20,       32'h5,        32'h5,        0, 32'h80,       1, 32'h120,       1, 0, 0);
    tbl[4]  = mk(bk_bltu,    32'h8,        32'h40,       32'hFFFFFFFF, 32'h1,        0, 32'h8,        0, 32'h0,         0, 0, 0);
    tbl[5]  = mk(bk_bltu,    32'h8,        32'h40,       32'hFFFFFFFF, 32'h1,        0, 32'h8,        0, 32'h0,         0, 0, 0);
    tbl[6]  = mk(bk_beq,     32'h8,        32'h10,       32'h7,        32'h7,        0, 32'h8,        1, 32'h18,        0, 0, 0);
    tbl[7]  = mk(bk_blt,     32'h204,      32'h10,       32'hFFFFFFFF, 32'h1,        1, 32'h204,      0, 32'h0,         1, 0, 0);
    tbl[8]  = mk(bk_bge,     32'h204,      32'h10,       32'hFFFFFFFF, 32'h1,        1, 32'h204,      1, 32'h208,       0, 0, 5);
    tbl[9]  = mk(bk_bgeu,    32'h30,       32'hFFFFFFF0, 32'h3,        32'h3,        0, 32'h30,       1, 32'h20,        1, 0, 0);
    tbl[10] = mk(bk_bgeu,    32'h30,       32'hFFFFFFF0, 32'h2,        32'h3,        0, 32'h30,       0, 32'h0,         0, 0, 0);
    tbl[11] = mk(bk_blt,     32'h30,       32'hFFFFFFF0, 32'h5,        32'hFFFFFFFB, 0, 32'h30,       0, 32'h0,         0, 0, 0);
    tbl[12] = mk(bk_bltu,    32'h30,       32'hFFFFFFF0, 32'h5,        32'hFFFFFFFB, 0, 32'h30,       1, 32'h20,        0, 0, 0);
    tbl[13] = mk(bk_bne,     32'hFFFFFFFC, 32'h8,        32'h9,        32'h9,        1, 32'hFFFFFFFC, 1, 32'h0,         0, 0, 0);
    tbl[14] = mk(bk_beq,     32'hFFFFFFF8, 32'h10,       32'h1,        32'h1,        0, 32'hFFFFFFF8, 1, 32'h8,         1, 0, 0);
    tbl[15] = mk(bk_bge,     32'h10,       32'h40,       32'h80000000, 32'h7FFFFFFF, 1, 32'h10,       1, 32'h14,        0, 0, 0);
    tbl[16] = mk(bk_bgeu,    32'h10,       32'h40,       32'h80000000, 32'h7FFFFFFF, 0, 32'h10,       1, 32'h50,        0, 0, 0);
    tbl[17] = mk(bk_invalid, 32'h40,       32'h100,      32'h1,        32'h1,        0, 32'h40,       0, 32'h0,         1, 1, 0);

    bus.br_valid      = 1'b0;
    bus.br_kind       = bk_beq;
    bus.br_pc         = '0;
    bus.br_imm        = '0;
    bus.br_rs1        = '0;
    bus.br_rs2        = '0;
    bus.br_pred_taken = 1'b0;
    bus.pred_pc       = '0;
    bus.redir_ready   = 1'b0;

    // reset state
    #1;
    check("rst_br_ready", bus.br_ready, 0);
    check("rst_redir_valid", bus.redir_valid, 0);
    check("rst_flush", bus.flush, 0);
    check("rst_illegal", bus.illegal, 0);
    check("rst_redir_pc", bus.redir_pc, 0);
    check("rst_pred_taken", bus.pred_taken, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("post_rst_br_ready", bus.br_ready, 1);

    for (int k = 0; k < 18; k++) send(tbl[k], k);

    // The illegal flag lasts a single cycle.
    @(negedge clk);
    check("illegal_pulse_end", bus.illegal, 0);

    // Reset while a redirect is pending.
    drive_branch(mk(bk_beq, 32'h40, 32'h100, 32'h1, 32'h1, 0, 32'h40, 1, 32'h140, 1, 0, 0));
    void'(exp_q.pop_front());
    check("mid_redir_valid", bus.redir_valid, 1);
    check("mid_redir_pc", bus.redir_pc, 32'h140);
    #2;
    rst = 1'b0;
    #1;
    check("async_redir_valid", bus.redir_valid, 0);
    check("async_flush", bus.flush, 0);
    check("async_br_ready", bus.br_ready, 0);
    check("async_redir_pc", bus.redir_pc, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.pred_pc = 32'(i) << 2;
      #1;
      check($sformatf("rst_bht_%0d", i), bus.pred_taken, 0);
    end
    @(negedge clk);
    check("rerst_br_ready", bus.br_ready, 1);
    // Counter 01 drops to 00 on a not-taken branch; a stale 11 would show as 1.
    send(mk(bk_beq, 32'h40, 32'h100, 32'h1, 32'h2, 0, 32'h40, 0, 32'h0, 0, 0, 0), 18);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
